inst_fetch_buffer: RTL

- 2-wide instruction FIFO between the fetch stage and the decode/ID stage.
- Decouples fetch bursts from decode stalls, including stalls caused by single-issue splitting in the issue logic downstream.
- Accepts 0-2 instructions per cycle and presents up to 2 in program order as slot0/slot1.
- Pads a missing slot1 with a NOP bubble.

---
 rtl/inst_fetch_buffer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_buffer.sv
// 2-wide instruction FIFO between fetch and decode, presenting up to two entries in program order.
// Optional macro FB_BYPASS_EN: when empty, the incoming pair is presented in the same cycle.
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif

module inst_fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        if_readygo,
  output logic        fb_allowin,
  input  logic [1:0]  if_valid,
  input  logic [31:0] if_pc0,
  input  logic [31:0] if_pc1,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [1:0]  if_excp,
  input  logic [6:0]  if_exception,
  input  logic [31:0] if_badv,
  output logic        fb_readygo,
  input  logic        id_allowin,
  output logic [1:0]  fb_valid,
  output logic [31:0] fb_pc0,
  output logic [31:0] fb_pc1,
  output logic [31:0] fb_inst0,
  output logic [31:0] fb_inst1,
  output logic [1:0]  fb_excp,
  output logic [6:0]  fb_exception,
  output logic [31:0] fb_badv
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] headPtr_q, headPtr_d, tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pcMem_q   [DEPTH];
  logic [31:0] instMem_q [DEPTH];
  logic        excpMem_q [DEPTH];
  logic [6:0]  excMem_q  [DEPTH];
  logic [31:0] badvMem_q [DEPTH];

  logic [PTR_W-1:0] headPlus1, tailPlus1;
  logic             pushEn, popEn, bypassConsume;
  logic [1:0]       pushNum, popNum;
  logic             wrEn0, wrEn1;
  logic [31:0]      wrPc0, wrInst0;
  logic             wrExcp0;
  logic [6:0]       slotExc0, slotExc1;
  logic [31:0]      slotBadv0, slotBadv1;

  assign headPlus1  = headPtr_q + PTR_W'(1);
  assign tailPlus1  = tailPtr_q + PTR_W'(1);
  assign fb_allowin = (count_q <= CNT_W'(DEPTH - 2));

`ifdef FB_BYPASS_EN
  // A bypassed pair that decode takes right away never occupies storage.
  assign bypassConsume = (count_q == '0) && if_readygo && id_allowin;
`else
  assign bypassConsume = 1'b0;
`endif

  assign pushEn = if_readygo && fb_allowin && !flush && !bypassConsume;
  assign popEn  = (count_q != '0) && id_allowin && !flush;

  always_comb begin
    wrEn0   = 1'b0;
    wrEn1   = 1'b0;
    wrPc0   = if_pc0;
    wrInst0 = if_inst0;
    wrExcp0 = if_excp[0];
    pushNum = 2'd0;
    if (pushEn) begin
      unique case (if_valid)
        2'b11: begin wrEn0 = 1'b1; wrEn1 = 1'b1; pushNum = 2'd2; end
        2'b01: begin wrEn0 = 1'b1; pushNum = 2'd1; end
        2'b10: begin
          // A lone slot1 instruction is compacted into the tail entry.
          wrEn0   = 1'b1;
          wrPc0   = if_pc1;
          wrInst0 = if_inst1;
          wrExcp0 = if_excp[1];
          pushNum = 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    popNum = 2'd0;
    if (popEn) popNum = (count_q >= CNT_W'(2)) ? 2'd2 : 2'd1;
  end

  always_comb begin
    headPtr_d = headPtr_q + PTR_W'(popNum);
    tailPtr_d = tailPtr_q + PTR_W'(pushNum);
    count_d   = count_q + CNT_W'(pushNum) - CNT_W'(popNum);
    if (flush) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn0) begin
      pcMem_q[tailPtr_q]   <= wrPc0;
      instMem_q[tailPtr_q] <= wrInst0;
      excpMem_q[tailPtr_q] <= wrExcp0;
      excMem_q[tailPtr_q]  <= if_exception;
      badvMem_q[tailPtr_q] <= if_badv;
    end
    if (wrEn1) begin
      pcMem_q[tailPlus1]   <= if_pc1;
      instMem_q[tailPlus1] <= if_inst1;
      excpMem_q[tailPlus1] <= if_excp[1];
      excMem_q[tailPlus1]  <= if_exception;
      badvMem_q[tailPlus1] <= if_badv;
    end
  end

  always_comb begin
    fb_valid   = 2'b00;
    fb_pc0     = `PC_RESET;
    fb_inst0   = `INST_NOP;
    fb_pc1     = `PC_RESET;
    fb_inst1   = `INST_NOP;
    fb_excp    = 2'b00;
    slotExc0   = '0;
    slotExc1   = '0;
    slotBadv0  = '0;
    slotBadv1  = '0;
    fb_readygo = (count_q != '0);
    if (count_q >= CNT_W'(2)) begin
      fb_valid  = 2'b11;
      fb_pc0    = pcMem_q[headPtr_q];
      fb_inst0  = instMem_q[headPtr_q];
      fb_excp   = {excpMem_q[headPlus1], excpMem_q[headPtr_q]};
      slotExc0  = excMem_q[headPtr_q];
      slotBadv0 = badvMem_q[headPtr_q];
      fb_pc1    = pcMem_q[headPlus1];
      fb_inst1  = instMem_q[headPlus1];
      slotExc1  = excMem_q[headPlus1];
      slotBadv1 = badvMem_q[headPlus1];
    end else if (count_q == CNT_W'(1)) begin
      fb_valid  = 2'b01;
      fb_pc0    = pcMem_q[headPtr_q];
      fb_inst0  = instMem_q[headPtr_q];
      fb_excp   = {1'b0, excpMem_q[headPtr_q]};
      slotExc0  = excMem_q[headPtr_q];
      slotBadv0 = badvMem_q[headPtr_q];
    end
`ifdef FB_BYPASS_EN
    else if (if_readygo) begin
      fb_readygo = |if_valid;
      slotExc0   = if_exception;
      slotBadv0  = if_badv;
      slotExc1   = if_exception;
      slotBadv1  = if_badv;
      unique case (if_valid)
        2'b11: begin
          fb_valid = 2'b11;
          fb_pc0   = if_pc0;
          fb_inst0 = if_inst0;
          fb_pc1   = if_pc1;
          fb_inst1 = if_inst1;
          fb_excp  = if_excp;
        end
        2'b01: begin
          fb_valid = 2'b01;
          fb_pc0   = if_pc0;
          fb_inst0 = if_inst0;
          fb_excp  = {1'b0, if_excp[0]};
        end
        2'b10: begin
          fb_valid = 2'b01;
          fb_pc0   = if_pc1;
          fb_inst0 = if_inst1;
          fb_excp  = {1'b0, if_excp[1]};
        end
        default: ;
      endcase
    end
`endif
    // Report the oldest excepting presented entry.
    fb_exception = '0;
    fb_badv      = '0;
    if (fb_excp[0]) begin
      fb_exception = slotExc0;
      fb_badv      = slotBadv0;
    end else if (fb_excp[1]) begin
      fb_exception = slotExc1;
      fb_badv      = slotBadv1;
    end
  end

endmodule
